// File: rtl/commit_monitor.sv
// Retire-side commit monitor: registers commits for the debugger, counts retires, keeps a PC ring trace, halts on trap/watchdog.
// Latency: a commit accepted at edge N is visible on dbg_* during cycle N+1; trace reads are combinational.
// Backpressure: wb_ready is high only in RUN and is decoded from state alone, never from wb_valid.
module commit_monitor #(
    parameter int TRACE_DEPTH = 8,
    parameter int TIMEOUT     = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wb_valid,
    output logic                           wb_ready,
    input  logic [31:0]                    wb_pc,
    input  logic [31:0]                    wb_inst,
    input  logic                           wb_is_ebreak,
    input  logic                           wb_is_invalid,
    output logic [31:0]                    dbg_pc,
    output logic [31:0]                    dbg_inst,
    output logic                           dbg_valid,
    output logic                           dbg_is_ebreak,
    output logic                           dbg_is_invalid,
    output logic                           halted,
    output logic [1:0]                     halt_cause,
    output logic [63:0]                    retire_cnt,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [31:0]                    trace_pc,
    output logic                           trace_hit
);

    localparam int PW = $clog2(TRACE_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FILL_FULL = CW'(TRACE_DEPTH);
    localparam logic [TW-1:0] IDLE_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_TRAP = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     dbg_pc_q, dbg_pc_d;
    logic [31:0]     dbg_inst_q, dbg_inst_d;
    logic            dbg_valid_q, dbg_valid_d;
    logic            dbg_eb_q, dbg_eb_d;
    logic            dbg_inv_q, dbg_inv_d;
    logic [1:0]      cause_q, cause_d;
    logic [63:0]     cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   fill_q, fill_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic [TW-1:0]   idle_inc;
    logic [31:0]     mem_q [TRACE_DEPTH];
    logic            fire;
    logic [PW-1:0]   rd_ptr;

    assign wb_ready = (state_q == S_RUN);
    assign fire     = wb_valid & wb_ready;
    assign idle_inc = idle_q + TW'(1);

    // Next-state: commit capture, retire/trace bookkeeping, trap and watchdog transitions.
    always_comb begin
        state_d     = state_q;
        dbg_pc_d    = dbg_pc_q;
        dbg_inst_d  = dbg_inst_q;
        dbg_valid_d = fire;
        dbg_eb_d    = fire & wb_is_ebreak;
        dbg_inv_d   = fire & wb_is_invalid;
        cause_d     = cause_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        idle_d      = idle_q;
        case (state_q)
            S_RUN: begin
                if (fire) begin
                    dbg_pc_d   = wb_pc;
                    dbg_inst_d = wb_inst;
                    cnt_d      = cnt_q + 64'd1;
                    wr_ptr_d   = wr_ptr_q + PW'(1);
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + CW'(1);
                    end
                    idle_d = '0;
                    // Invalid takes priority over ebreak when both are flagged.
                    if (wb_is_invalid) begin
                        state_d = S_TRAP;
                        cause_d = 2'd2;
                    end else if (wb_is_ebreak) begin
                        state_d = S_TRAP;
                        cause_d = 2'd1;
                    end
                end else begin
                    idle_d = idle_inc;
                    if (idle_inc == IDLE_MAX) begin
                        state_d = S_HALT;
                        cause_d = 2'd3;
                    end
                end
            end
            S_TRAP:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // State registers with synchronous reset; reset also drops any commit presented this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            dbg_pc_q    <= '0;
            dbg_inst_q  <= '0;
            dbg_valid_q <= 1'b0;
            dbg_eb_q    <= 1'b0;
            dbg_inv_q   <= 1'b0;
            cause_q     <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            dbg_pc_q    <= dbg_pc_d;
            dbg_inst_q  <= dbg_inst_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_eb_q    <= dbg_eb_d;
            dbg_inv_q   <= dbg_inv_d;
            cause_q     <= cause_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            idle_q      <= idle_d;
        end
    end

    // Trace storage is not reset; the fill count masks stale entries.
    always_ff @(posedge clk) begin
        if (fire && !reset) begin
            mem_q[wr_ptr_q] <= wb_pc;
        end
    end

    // Index 0 is the newest entry, one slot behind the write pointer.
    assign rd_ptr    = wr_ptr_q - PW'(1) - trace_idx;
    assign trace_hit = ({1'b0, trace_idx} < fill_q);
    assign trace_pc  = trace_hit ? mem_q[rd_ptr] : 32'd0;

    assign dbg_pc         = dbg_pc_q;
    assign dbg_inst       = dbg_inst_q;
    assign dbg_valid      = dbg_valid_q;
    assign dbg_is_ebreak  = dbg_eb_q;
    assign dbg_is_invalid = dbg_inv_q;
    assign halted         = (state_q == S_HALT);
    assign halt_cause     = cause_q;
    assign retire_cnt     = cnt_q;

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: directed commit sequences checked against a queue-based retire model.
// Latency: model expects dbg_* one cycle after acceptance; trace compared for every index each cycle.
// Backpressure: model accepts only while it believes the monitor is running.
module tb_commit_monitor;

    localparam int TD = 8;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [31:0] wb_pc = '0;
    logic [31:0] wb_inst = '0;
    logic        wb_is_ebreak = 1'b0;
    logic        wb_is_invalid = 1'b0;
    logic [31:0] dbg_pc;
    logic [31:0] dbg_inst;
    logic        dbg_valid;
    logic        dbg_is_ebreak;
    logic        dbg_is_invalid;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [63:0] retire_cnt;
    logic [2:0]  trace_idx = '0;
    logic [31:0] trace_pc;
    logic        trace_hit;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int pulses = 0;

    commit_monitor #(.TRACE_DEPTH(TD), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_pc(wb_pc), .wb_inst(wb_inst),
        .wb_is_ebreak(wb_is_ebreak), .wb_is_invalid(wb_is_invalid),
        .dbg_pc(dbg_pc), .dbg_inst(dbg_inst), .dbg_valid(dbg_valid),
        .dbg_is_ebreak(dbg_is_ebreak), .dbg_is_invalid(dbg_is_invalid),
        .halted(halted), .halt_cause(halt_cause), .retire_cnt(retire_cnt),
        .trace_idx(trace_idx), .trace_pc(trace_pc), .trace_hit(trace_hit)
    );

    always #10 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode: 0 running, 1 trap cycle, 2 halted
    int              m_mode = 0;
    longint unsigned m_cnt = 0;
    int unsigned     m_hist[$];
    logic [31:0]     m_pc = '0, m_inst = '0;
    bit              m_valid = 0, m_eb = 0, m_inv = 0;
    int              m_cause = 0;
    int              m_idle = 0;

    function automatic logic [31:0] m_tr(int i);
        return (i < m_hist.size()) ? m_hist[i] : 32'd0;
    endfunction

    function automatic bit m_hit(int i);
        return i < m_hist.size();
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_hist.delete();
            m_pc = '0; m_inst = '0; m_valid = 0; m_eb = 0; m_inv = 0;
            m_cause = 0; m_idle = 0;
        end else begin
            bit f;
            f = wb_valid && (m_mode == 0);
            m_valid = f; m_eb = f && wb_is_ebreak; m_inv = f && wb_is_invalid;
            if (m_mode == 0) begin
                if (f) begin
                    m_pc = wb_pc; m_inst = wb_inst; m_cnt++;
                    m_hist.push_front(wb_pc); m_idle = 0;
                    if (wb_is_invalid) begin m_mode = 1; m_cause = 2; end
                    else if (wb_is_ebreak) begin m_mode = 1; m_cause = 1; end
                end else begin
                    m_idle++;
                    if (m_idle == TO) begin m_mode = 2; m_cause = 3; end
                end
            end else begin
                m_mode = 2;
            end
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model, sweeping all trace indices.
    always @(negedge clk) begin
        if (dbg_valid === 1'b1) pulses++;
        if (chk_en) begin
            check("wb_ready", 64'(wb_ready), 64'(m_mode == 0));
            check("halted", 64'(halted), 64'(m_mode == 2));
            check("halt_cause", 64'(halt_cause), 64'(m_cause));
            check("retire_cnt", retire_cnt, m_cnt);
            check("dbg_valid", 64'(dbg_valid), 64'(m_valid));
            check("dbg_is_ebreak", 64'(dbg_is_ebreak), 64'(m_eb));
            check("dbg_is_invalid", 64'(dbg_is_invalid), 64'(m_inv));
            check("dbg_pc", 64'(dbg_pc), 64'(m_pc));
            check("dbg_inst", 64'(dbg_inst), 64'(m_inst));
            for (int i = 0; i < TD; i++) begin
                trace_idx = 3'(i);
                #1;
                check($sformatf("trace_hit[%0d]", i), 64'(trace_hit), 64'(m_hit(i)));
                check($sformatf("trace_pc[%0d]", i), 64'(trace_pc), 64'(m_tr(i)));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic commit(logic [31:0] pc, logic [31:0] inst, bit eb, bit inv);
        wb_valid = 1'b1; wb_pc = pc; wb_inst = inst;
        wb_is_ebreak = eb; wb_is_invalid = inv;
        @(posedge clk); #1;
        wb_valid = 1'b0; wb_is_ebreak = 1'b0; wb_is_invalid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int p0;
        // Reset with a commit presented: it must be dropped.
        wb_valid = 1'b1; wb_pc = 32'hDEAD0000;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        chk_en = 1;
        check("rst_wb_ready", 64'(wb_ready), 64'd1);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_cnt", retire_cnt, 64'd0);
        check("rst_dbg_valid", 64'(dbg_valid), 64'd0);
        reset = 1'b0;

        // Three plain commits.
        p0 = pulses;
        commit(32'h80000000, 32'h00000013, 0, 0);
        commit(32'h80000004, 32'h00000013, 0, 0);
        commit(32'h80000008, 32'h00000013, 0, 0);
        idle(2);
        check("three_cnt", retire_cnt, 64'd3);
        check("three_pulses", 64'(pulses - p0), 64'd3);
        check("three_dbg_pc", 64'(dbg_pc), 64'h80000008);
        check("model_tr0", 64'(m_tr(0)), 64'h80000008);
        check("model_tr2", 64'(m_tr(2)), 64'h80000000);
        check("model_hit3", 64'(m_hit(3)), 64'd0);

        // Ten commits wrap the 8-entry ring.
        do_reset();
        for (int k = 1; k <= 10; k++) commit(32'h1000 + 32'(4 * k), 32'h13, 0, 0);
        idle(1);
        check("ten_cnt", retire_cnt, 64'd10);
        check("model_ten_tr0", 64'(m_tr(0)), 64'h1028);
        check("model_ten_tr7", 64'(m_tr(7)), 64'h100C);
        check("model_ten_hit7", 64'(m_hit(7)), 64'd1);

        // Ebreak trap, then ignored commits, then reset from HALT.
        do_reset();
        commit(32'h100, 32'h13, 0, 0);
        commit(32'h104, 32'h00100073, 1, 0);
        check("eb_dbg_valid", 64'(dbg_valid), 64'd1);
        check("eb_pulse", 64'(dbg_is_ebreak), 64'd1);
        check("eb_inv_pulse", 64'(dbg_is_invalid), 64'd0);
        check("eb_trap_ready", 64'(wb_ready), 64'd0);
        check("eb_dbg_inst", 64'(dbg_inst), 64'h00100073);
        idle(1);
        check("eb_halted", 64'(halted), 64'd1);
        check("eb_cause", 64'(halt_cause), 64'd1);
        check("eb_halt_valid", 64'(dbg_valid), 64'd0);
        wb_valid = 1'b1; wb_pc = 32'h200;
        idle(3);
        wb_valid = 1'b0;
        check("eb_frozen_cnt", retire_cnt, 64'd2);
        check("eb_hold_pc", 64'(dbg_pc), 64'h104);
        do_reset();
        check("halt_rst_ready", 64'(wb_ready), 64'd1);
        check("halt_rst_cnt", retire_cnt, 64'd0);
        check("halt_rst_cause", 64'(halt_cause), 64'd0);

        // Ebreak and invalid together: invalid wins; reset during TRAP.
        commit(32'h300, 32'hFFFFFFFF, 1, 1);
        check("both_eb", 64'(dbg_is_ebreak), 64'd1);
        check("both_inv", 64'(dbg_is_invalid), 64'd1);
        check("both_cause", 64'(halt_cause), 64'd2);
        do_reset();
        check("trap_rst_ready", 64'(wb_ready), 64'd1);
        check("trap_rst_halted", 64'(halted), 64'd0);
        check("trap_rst_cnt", retire_cnt, 64'd0);

        // Invalid alone.
        commit(32'h400, 32'h0, 0, 1);
        idle(1);
        check("inv_halted", 64'(halted), 64'd1);
        check("inv_cause", 64'(halt_cause), 64'd2);

        // Watchdog: 16 idle cycles halt with cause 3 and no debugger pulse.
        do_reset();
        p0 = pulses;
        idle(TO - 1);
        check("wd_not_yet", 64'(halted), 64'd0);
        idle(1);
        check("wd_halted", 64'(halted), 64'd1);
        check("wd_cause", 64'(halt_cause), 64'd3);
        check("wd_no_pulse", 64'(pulses - p0), 64'd0);

        // A commit on the 16th cycle wins and restarts the timer.
        do_reset();
        idle(TO - 1);
        commit(32'h500, 32'h13, 0, 0);
        check("wd_fire_wins", 64'(halted), 64'd0);
        idle(TO - 1);
        check("wd_restart_run", 64'(halted), 64'd0);
        idle(1);
        check("wd_restart_halt", 64'(halted), 64'd1);
        idle(2);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "bench timeout");
    end

endmodule
